// File: rtl/evt_stream_gen.sv
// AXI4-Stream event word generator: packetised runs with optional inter-packet gaps.
// Define EVT_STREAM_GEN_LFSR_EN to replace the counter payload with a 64-bit Galois LFSR.
module evt_stream_gen #(
    parameter int COUNT_WIDTH_G = 32,
    parameter int PKT_WIDTH_G   = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic [COUNT_WIDTH_G-1:0] nb_words_i,
    input  logic [PKT_WIDTH_G-1:0]   packet_len_i,
    input  logic [7:0]               gap_i,
    input  logic                     out_ready_i,
    output logic                     out_valid_o,
    output logic [63:0]              out_data_o,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [COUNT_WIDTH_G-1:0] word_cnt_o
);

    localparam logic [COUNT_WIDTH_G-1:0] CNT_ZERO = COUNT_WIDTH_G'(0);
    localparam logic [COUNT_WIDTH_G-1:0] CNT_ONE  = COUNT_WIDTH_G'(1);
    localparam logic [PKT_WIDTH_G-1:0]   PKT_ZERO = PKT_WIDTH_G'(0);
    localparam logic [PKT_WIDTH_G-1:0]   PKT_ONE  = PKT_WIDTH_G'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     valid_q, valid_d;
    logic [63:0]              data_q, data_d;
    logic                     last_q, last_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     stop_q, stop_d;
    logic [COUNT_WIDTH_G-1:0] idx_q, idx_d;
    logic [COUNT_WIDTH_G-1:0] nb_q, nb_d;
    logic [PKT_WIDTH_G-1:0]   pkt_q, pkt_d;
    logic [PKT_WIDTH_G-1:0]   pos_q, pos_d;
    logic [7:0]               gap_q, gap_d;
    logic [7:0]               gap_cnt_q, gap_cnt_d;

    logic [PKT_WIDTH_G-1:0]   pkt_eff_s;
    logic                     start_last_s;
    logic [COUNT_WIDTH_G-1:0] idx_inc_s;
    logic                     final_s;
    logic [PKT_WIDTH_G-1:0]   next_pos_s;
    logic                     next_last_s;
    logic                     resume_last_s;
    logic                     accept_s;
    logic [63:0]              pay_start_s;
    logic [63:0]              pay_next_s;
    logic [63:0]              pay_resume_s;

    assign accept_s      = valid_q & out_ready_i;
    assign pkt_eff_s     = (packet_len_i == PKT_ZERO) ? PKT_ONE : packet_len_i;
    assign start_last_s  = (pkt_eff_s == PKT_ONE) || (nb_words_i == CNT_ONE);
    assign idx_inc_s     = idx_q + CNT_ONE;
    assign final_s       = (idx_inc_s == nb_q);
    // The beat after a packet end restarts the in-packet position at zero.
    assign next_pos_s    = last_q ? PKT_ZERO : (pos_q + PKT_ONE);
    assign next_last_s   = (next_pos_s == (pkt_q - PKT_ONE)) || ((idx_inc_s + CNT_ONE) == nb_q);
    assign resume_last_s = (pkt_q == PKT_ONE) || ((idx_q + CNT_ONE) == nb_q);

`ifdef EVT_STREAM_GEN_LFSR_EN
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        logic [63:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ LFSR_TAPS;
        end else begin
            r = r;
        end
        return r;
    endfunction

    logic [63:0] lfsr_q, lfsr_d;

    // LFSR next state: reseed on accepted start, advance on each accepted beat.
    always_comb begin
        lfsr_d = lfsr_q;
        if ((state_q == IDLE) && start_i) begin
            lfsr_d = 64'h1;
        end else if ((state_q == RUN) && accept_s) begin
            lfsr_d = lfsr_step(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (srst) begin
            lfsr_q <= 64'h1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign pay_start_s  = 64'h1;
    assign pay_next_s   = lfsr_step(lfsr_q);
    assign pay_resume_s = lfsr_q;
`else
    function automatic logic [63:0] cnt_payload(input logic [COUNT_WIDTH_G-1:0] idx);
        logic [31:0] lo;
        lo = 32'(idx);
        return {~lo, lo};
    endfunction

    assign pay_start_s  = cnt_payload(CNT_ZERO);
    assign pay_next_s   = cnt_payload(idx_inc_s);
    assign pay_resume_s = cnt_payload(idx_q);
`endif

    // Next-state and next-output logic for the run controller.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        stop_d    = stop_q;
        idx_d     = idx_q;
        nb_d      = nb_q;
        pkt_d     = pkt_q;
        pos_d     = pos_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    nb_d   = nb_words_i;
                    pkt_d  = pkt_eff_s;
                    gap_d  = gap_i;
                    idx_d  = CNT_ZERO;
                    pos_d  = PKT_ZERO;
                    stop_d = 1'b0;
                    if (nb_words_i == CNT_ZERO) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        valid_d = 1'b1;
                        data_d  = pay_start_s;
                        last_d  = start_last_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    idx_d = idx_inc_s;
                    if (final_s || stop_i || stop_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else if (last_q && (gap_q != 8'd0)) begin
                        state_d   = GAP;
                        valid_d   = 1'b0;
                        last_d    = 1'b0;
                        gap_cnt_d = gap_q;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = pay_next_s;
                        last_d  = next_last_s;
                        pos_d   = next_pos_s;
                    end
                end else begin
                    // A stop seen during a stall is remembered until the beat is taken.
                    stop_d = stop_q | stop_i;
                end
            end
            GAP: begin
                if (stop_i) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == 8'd1) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    data_d  = pay_resume_s;
                    last_d  = resume_last_s;
                    pos_d   = PKT_ZERO;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            data_q    <= 64'h0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stop_q    <= 1'b0;
            idx_q     <= CNT_ZERO;
            nb_q      <= CNT_ZERO;
            pkt_q     <= PKT_ONE;
            pos_q     <= PKT_ZERO;
            gap_q     <= 8'd0;
            gap_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            stop_q    <= stop_d;
            idx_q     <= idx_d;
            nb_q      <= nb_d;
            pkt_q     <= pkt_d;
            pos_q     <= pos_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign word_cnt_o  = idx_q;

endmodule

// File: tb/tb_evt_stream_gen.sv
// Directed bench for evt_stream_gen: a per-run beat model is compared against every accepted beat,
// plus hand-computed timing and payload expectations.
module tb_evt_stream_gen;

    localparam int CW = 32;
    localparam int PW = 16;

    logic          clk   = 1'b0;
    logic          srst  = 1'b1;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          ready = 1'b1;
    logic [CW-1:0] nb    = '0;
    logic [PW-1:0] pkt   = '0;
    logic [7:0]    gap   = 8'd0;
    logic          valid;
    logic [63:0]   data;
    logic          last;
    logic          busy;
    logic          done;
    logic [CW-1:0] wcnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] exp_data[$];
    logic        exp_last[$];
    logic [63:0] acc_data[$];
    logic        acc_last[$];
    int          acc_cyc[$];

    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = 64'h0;
    logic        prev_last  = 1'b0;

    evt_stream_gen #(.COUNT_WIDTH_G(CW), .PKT_WIDTH_G(PW)) dut (
        .clk(clk), .srst(srst), .start_i(start), .stop_i(stop),
        .nb_words_i(nb), .packet_len_i(pkt), .gap_i(gap), .out_ready_i(ready),
        .out_valid_o(valid), .out_data_o(data), .out_last_o(last),
        .busy_o(busy), .done_o(done), .word_cnt_o(wcnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic report(input string name, input bit ok, input string detail);
        total = total + 1;
        if (!ok) begin
            bad = bad + 1;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        report(name, act === exp, $sformatf("got %h want %h", act, exp));
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        report(name, act === exp, $sformatf("got %b want %b", act, exp));
    endtask

    task automatic chki(input string name, input int act, input int exp);
        report(name, act == exp, $sformatf("got %0d want %0d", act, exp));
    endtask

    // Polynomial x^64+x^63+x^61+x^60+1, right-shifting Galois form.
    function automatic logic [63:0] ref_lfsr(input logic [63:0] s);
        logic [63:0] r;
        r = s >> 1;
        if (s[0]) begin
            r[63] = ~r[63];
            r[62] = ~r[62];
            r[60] = ~r[60];
            r[59] = ~r[59];
        end
        return r;
    endfunction

    // Expected beat list of one complete run, straight from the payload and packet rules.
    task automatic model_run(input int n, input int p);
        logic [63:0] lf;
        logic [31:0] k32;
        int pe;
        pe = (p == 0) ? 1 : p;
        lf = 64'h1;
        exp_data.delete();
        exp_last.delete();
        for (int k = 0; k < n; k++) begin
            k32 = 32'(k);
`ifdef EVT_STREAM_GEN_LFSR_EN
            exp_data.push_back(lf);
            lf = ref_lfsr(lf);
`else
            exp_data.push_back({~k32, k32});
`endif
            exp_last.push_back((((k + 1) % pe) == 0) || (k == n - 1));
        end
    endtask

    // Compare process: every accepted beat against the model, and stall stability.
    always @(negedge clk) begin
        if (srst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk1("stall_valid", valid, 1'b1);
                chk64("stall_data", data, prev_data);
                chk1("stall_last", last, prev_last);
            end
            if (valid && ready) begin
                if (exp_data.size() == 0) begin
                    report("unexpected_beat", 1'b0, $sformatf("got beat %h want no beat", data));
                end else begin
                    chk64("beat_data", data, exp_data.pop_front());
                    chk1("beat_last", last, exp_last.pop_front());
                end
                acc_data.push_back(data);
                acc_last.push_back(last);
                acc_cyc.push_back(cyc);
            end
            prev_stall <= valid && !ready;
            prev_data  <= data;
            prev_last  <= last;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, input int p, input int g, output int sc);
        model_run(n, p);
        acc_data.delete();
        acc_last.delete();
        acc_cyc.delete();
        nb    = CW'(n);
        pkt   = PW'(p);
        gap   = 8'(g);
        start = 1'b1;
        sc    = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget && dc < 0; i++) begin
            @(negedge clk);
            if (done) dc = cyc;
        end
        if (dc < 0) begin
            report("done_timeout", 1'b0, $sformatf("got no done_o want done_o within %0d cycles", budget));
        end else begin
            @(negedge clk);
            chk1("done_single", done, 1'b0);
            chk1("busy_after_done", busy, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int last_mask();
        int m;
        m = 0;
        foreach (acc_last[i]) if (acc_last[i]) m = m | (1 << i);
        return m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int dc;
        logic [63:0] first_run[$];

        tick(3);
        @(negedge clk);
        chk1("rst_valid", valid, 1'b0);
        chk64("rst_data", data, 64'h0);
        chk1("rst_last", last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk64("rst_wcnt", 64'(wcnt), 64'h0);
        @(posedge clk);
        #1;
        srst = 1'b0;
        tick(2);

        // nb=8, pkt=4, back-to-back; a second start mid-run must be ignored
        do_start(8, 4, 0, sc);
        tick(2);
        nb = 32'd3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(60, dc);
        chki("r8_count", acc_data.size(), 8);
        chki("r8_first_cyc", acc_cyc[0], sc + 1);
        chki("r8_last_cyc", acc_cyc[7], sc + 8);
        chki("r8_done_cyc", dc, sc + 9);
        chki("r8_last_mask", last_mask(), 'h88);
        chk64("r8_wcnt", 64'(wcnt), 64'd8);
        chki("r8_drained", exp_data.size(), 0);
`ifndef EVT_STREAM_GEN_LFSR_EN
        chk64("r8_data0", acc_data[0], 64'hFFFF_FFFF_0000_0000);
        chk64("r8_data7", acc_data[7], 64'hFFFF_FFF8_0000_0007);
`endif

        // nb=5, pkt=2, gap=3
        do_start(5, 2, 3, sc);
        wait_done(60, dc);
        chki("g_count", acc_data.size(), 5);
        chki("g_mask", last_mask(), 'h1A);
        chki("g_nogap01", acc_cyc[1] - acc_cyc[0], 1);
        chki("g_gap12", acc_cyc[2] - acc_cyc[1], 4);
        chki("g_gap34", acc_cyc[4] - acc_cyc[3], 4);
        chki("g_done_cyc", dc, acc_cyc[4] + 1);
        chki("g_done_abs", dc, sc + 12);

        // nb=4, packet_len=0 (one beat per packet), 5-cycle stall on beat 2
        do_start(4, 0, 0, sc);
        tick(2);
        ready = 1'b0;
        tick(5);
        ready = 1'b1;
        wait_done(60, dc);
        chki("s_count", acc_data.size(), 4);
        chki("s_beat2_cyc", acc_cyc[2], sc + 8);
        chki("s_mask", last_mask(), 'hF);
        chki("s_done_cyc", dc, sc + 10);
        chki("s_drained", exp_data.size(), 0);

        // stop during stalled beat 3 of nb=100
        do_start(100, 8, 0, sc);
        tick(3);
        ready = 1'b0;
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        ready = 1'b1;
        wait_done(60, dc);
        chki("stop_count", acc_data.size(), 4);
        chki("stop_done_cyc", dc, sc + 8);
        chk64("stop_wcnt", 64'(wcnt), 64'd4);
        chk1("stop_last_unforced", acc_last[3], 1'b0);
        exp_data.delete();
        exp_last.delete();

        // stop while in a gap
        do_start(6, 2, 5, sc);
        tick(3);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_done(60, dc);
        chki("gstop_done_cyc", dc, sc + 5);
        chk64("gstop_wcnt", 64'(wcnt), 64'd2);
        exp_data.delete();
        exp_last.delete();

        // nb=0 goes straight to DONE
        do_start(0, 4, 0, sc);
        wait_done(20, dc);
        chki("z_done_cyc", dc, sc + 1);
        chki("z_count", acc_data.size(), 0);
        chk64("z_wcnt", 64'(wcnt), 64'd0);

        // stop in IDLE is ignored
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        @(negedge clk);
        chk1("idle_stop_busy", busy, 1'b0);
        chk1("idle_stop_done", done, 1'b0);
        chk1("idle_stop_valid", valid, 1'b0);
        tick(1);

        // srst mid-run with a pending beat
        do_start(50, 4, 0, sc);
        tick(2);
        ready = 1'b0;
        tick(1);
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
        @(negedge clk);
        chk1("mr_valid", valid, 1'b0);
        chk64("mr_data", data, 64'h0);
        chk1("mr_last", last, 1'b0);
        chk1("mr_busy", busy, 1'b0);
        chk1("mr_done", done, 1'b0);
        chk64("mr_wcnt", 64'(wcnt), 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("mr_no_done", done, 1'b0);
        end
        tick(1);
        ready = 1'b1;
        exp_data.delete();
        exp_last.delete();

        // nb=3 twice: payload must repeat exactly
        do_start(3, 1, 0, sc);
        wait_done(30, dc);
        first_run = acc_data;
        chki("rep1_count", acc_data.size(), 3);
`ifdef EVT_STREAM_GEN_LFSR_EN
        chk64("rep1_d0", acc_data[0], 64'h1);
        chk64("rep1_d1", acc_data[1], 64'hD800_0000_0000_0000);
        chk64("rep1_d2", acc_data[2], 64'h6C00_0000_0000_0000);
`else
        chk64("rep1_d0", acc_data[0], 64'hFFFF_FFFF_0000_0000);
        chk64("rep1_d1", acc_data[1], 64'hFFFF_FFFE_0000_0001);
        chk64("rep1_d2", acc_data[2], 64'hFFFF_FFFD_0000_0002);
`endif
        do_start(3, 1, 0, sc);
        wait_done(30, dc);
        chki("rep2_count", acc_data.size(), 3);
        for (int i = 0; i < 3; i++) chk64("rep2_same", acc_data[i], first_run[i]);
        chki("rep2_mask", last_mask(), 'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/evt_stream_gen.md
EVT_STREAM_GEN -- requirements
Module: evt_stream_gen

Interface
REQ-001 Parameter COUNT_WIDTH_G, default 32: width of the word-count and index counters.
REQ-002 Parameter PKT_WIDTH_G, default 16: width of the packet-length input.
REQ-003 Port clk, input, 1: the block's only clock; all logic is rising-edge.
REQ-004 Port srst, input, 1: synchronous, active-high reset.
REQ-005 Port start_i, input, 1: single-cycle request to begin a run.
REQ-006 Port stop_i, input, 1: request to abort the run at the next beat boundary.
REQ-007 Port nb_words_i, input, COUNT_WIDTH_G: total beats per run; sampled when the run starts.
REQ-008 Port packet_len_i, input, PKT_WIDTH_G: beats per packet; sampled when the run starts.
REQ-009 Port gap_i, input, 8: idle cycles inserted between packets; sampled when the run starts.
REQ-010 Port out_ready_i, input, 1: AXI4-Stream tready from the sink (DMA S2MM or evt recorder).
REQ-011 Port out_valid_o, output, 1: AXI4-Stream tvalid.
REQ-012 Port out_data_o, output, 64: AXI4-Stream tdata, one event word per beat.
REQ-013 Port out_last_o, output, 1: AXI4-Stream tlast, marking the final beat of a packet.
REQ-014 Port busy_o, output, 1: high while a run is in progress.
REQ-015 Port done_o, output, 1: single-cycle pulse when a run ends.
REQ-016 Port word_cnt_o, output, COUNT_WIDTH_G: number of accepted beats in the current or most recent run.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, RUN, GAP, DONE.
REQ-018 IDLE SHALL move to RUN when start_i=1, sampling nb_words_i, packet_len_i and gap_i in that cycle.
REQ-019 If start_i=1 with nb_words_i=0, the FSM SHALL go directly to DONE and emit no beat.
REQ-020 With start_i at cycle n, out_valid_o SHALL first be high at cycle n+1.
REQ-021 A beat is accepted when out_valid_o=1 and out_ready_i=1 in the same cycle.
REQ-022 While out_valid_o=1 and out_ready_i=0, out_data_o and out_last_o SHALL hold stable and out_valid_o SHALL stay high.
REQ-023 out_valid_o SHALL NOT depend combinationally on out_ready_i; back-to-back beats SHALL be sustained at 1 beat/cycle.
REQ-024 Default payload: out_data_o = {~idx[31:0], idx[31:0]}, where idx is the 0-based run beat index; idx increments on each accepted beat.
REQ-025 packet_len_i=0 SHALL be treated as 1.
REQ-026 out_last_o SHALL be 1 on every packet_len-th beat of a run and on the final beat of the run, even when nb_words is not a multiple of packet_len.
REQ-027 After an accepted last beat that is not the final beat: if gap>0, go to GAP for exactly gap cycles with out_valid_o=0, then return to RUN; if gap=0, stay in RUN with no bubble.
REQ-028 After the final beat is accepted, the FSM SHALL go to DONE.
REQ-029 DONE SHALL last one cycle, in which done_o=1, then return to IDLE.
REQ-030 stop_i in RUN SHALL let any pending beat complete its handshake, then go to DONE; out_last_o is not forced.
REQ-031 stop_i in GAP SHALL go to DONE on the next cycle.
REQ-032 start_i SHALL be ignored outside IDLE; stop_i SHALL be ignored in IDLE.
REQ-033 busy_o SHALL be 1 in RUN and GAP and 0 in IDLE and DONE.
REQ-034 word_cnt_o SHALL clear on an accepted start, increment on each accepted beat, and hold its value in IDLE.
REQ-035 Counters SHALL wrap modulo 2^COUNT_WIDTH_G; no overflow flag is provided.

Reset
REQ-036 While srst=1: state=IDLE; out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0, done_o=0, word_cnt_o=0; idx cleared; LFSR (when compiled in) loaded with 64'h1.
REQ-037 srst asserted mid-run SHALL drop out_valid_o on the next cycle with no done_o pulse, even if a beat is pending; this is the only permitted AXIS violation.

Configuration
REQ-038 With macro EVT_STREAM_GEN_LFSR_EN defined, out_data_o SHALL carry a 64-bit Galois LFSR (x^64+x^63+x^61+x^60+1) that is seeded to 64'h1 at each accepted start and advances once per accepted beat.
REQ-039 Without EVT_STREAM_GEN_LFSR_EN, the payload SHALL be the counter pattern of REQ-024 and no LFSR logic SHALL be synthesized.

Verification
REQ-040 Scenario: nb=8, pkt=4, gap=0, ready=1 -> 8 consecutive beats; data 0xFFFFFFFF_00000000 .. 0xFFFFFFF8_00000007; last on beats 3 and 7; done_o at the cycle after beat 7; word_cnt_o=8.
REQ-041 Scenario: nb=5, pkt=2, gap=3 -> last on beats 1, 3, 4; exactly 3 idle cycles after beats 1 and 3; none after beat 4.
REQ-042 Scenario: nb=4, ready low for 5 cycles at beat 2 -> beat 2 data/last held stable for those cycles; all 4 beats received in order.
REQ-043 Scenario: stop_i during a stalled beat 3 of nb=100 -> beat 3 completes, then done_o; word_cnt_o=4.
REQ-044 Scenario: start with nb=0 -> no valid, done_o at cycle n+1; srst asserted mid-run -> valid=0 next cycle, all outputs at reset values.
REQ-045 Scenario: EVT_STREAM_GEN_LFSR_EN defined, nb=3 -> data 0x1, then the next two LFSR states, matching a reference model; a repeated run reproduces the same sequence.
